ntt_scheduler: RTL and testbench
================================

# ntt_scheduler

Sequencing controller for one full Kyber NTT or inverse NTT over a 256-coefficient polynomial. It generates the in-place read/write address stream for the polynomial RAM, the twiddle ROM index and the butterfly mode. It also aligns write-back with the butterfly pipeline latency. Sits directly upstream of the butterfly core: its `rd_*`/`zeta_idx` drive the RAM/ROM whose outputs feed the core, and its delayed `wr_*` write the core outputs back.

## Interface
- `RAM_LAT`, 1: read latency of poly RAM and twiddle ROM (identical).
- `BF_LAT`, 5: butterfly latency in NTT and INTT modes.
- `MUL_LAT`, 4: butterfly latency in point-wise multiply mode (scale pass only).
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `inverse` in 1: 0 = forward NTT, 1 = INTT; sampled with `start`.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `bf_mode` out 2: 0 = NTT, 1 = INTT, 2 = MULT (scale pass); held for the whole operation.
- `rd_en` out 1: read strobe for pair/coefficient.
- `rd_addr_a`, `rd_addr_b` out 8: read addresses for butterfly inputs 1 and 2.
- `zeta_idx` out 7: twiddle ROM index, aligned with `rd_en`.
- `scale_sel` out 1: datapath selects constant f instead of ROM (scale pass).
- `wr_en_a`, `wr_en_b` out 1: write strobes for outputs 1 and 2.
- `wr_addr_a`, `wr_addr_b` out 8: write addresses.

## Operation
- States: IDLE, RUN, DRAIN, SCALE (macro only), SDRAIN (macro only), FIN.
- IDLE: `start`=1 latches `inverse`, clears layer l=0 and pair p=0, and goes to RUN.
- RUN: one pair per cycle, p = 0..127, with `rd_en`=1.
  - NTT: len = 128>>l, s = log2(len). INTT: len = 2<<l.
  - group = p>>s; a = {p[6:s], 0, p[s-1:0]}; b = a + len.
  - NTT: zeta_idx = (128/len) + group. INTT: zeta_idx = (256/len) − 1 − group.
  - p=127 goes to DRAIN.
- DRAIN: exactly RAM_LAT+BF_LAT cycles with no reads, for in-place RAW safety.
  - Then l<6: l++, p=0, RUN.
  - l=6: FIN, or SCALE if the macro is enabled and `inverse`.
- Write pipeline: shift registers of depth RAM_LAT+BF_LAT carry {valid, a, b}.
  - Each `rd_en` produces `wr_en_a`=`wr_en_b`=1 with the same addresses exactly RAM_LAT+BF_LAT cycles later.
- FIN: `done`=1 for one cycle, `busy`=0, then IDLE.
- `busy`=1 in every state except IDLE and FIN.
- `start` while not in IDLE is ignored; no queuing.
- `rst` at any time:
  - Returns to IDLE and clears the write pipeline; in-flight writes are squashed.
  - All outputs go to 0, including `bf_mode`=0.
- `rd_addr_*`, `zeta_idx` are 0 whenever `rd_en`=0.

## Timing
- `start` sampled at cycle 0; first `rd_en` at cycle 1.
- Layer k reads occupy cycles 1+134k .. 128+134k; drain follows (PIPE = 6 with defaults).
- Final write at cycle 938; `done` at cycle 939; `busy`=1 on cycles 1..938.
- Writes in layer k land before the first read of layer k+1 (RAM is read-after-write safe one cycle later).

## Configuration
- `NTT_INTT_SCALE_EN` defined, inverse operations only:
  - After layer 6 drain, enter SCALE: 256 cycles, `rd_en`=1, rd_addr_b = i (i = 0..255), rd_addr_a = 0.
  - SCALE drives `bf_mode`=2, `scale_sel`=1, zeta_idx = 0.
  - Writes appear RAM_LAT+MUL_LAT cycles later on `wr_en_b`/`wr_addr_b` only; `wr_en_a`=0.
  - SDRAIN lasts RAM_LAT+MUL_LAT cycles, then FIN.
  - INTT timing: scale reads on cycles 939..1194, writes on 944..1199, `done` at 1200.
- `NTT_INTT_SCALE_EN` undefined: SCALE/SDRAIN are absent, `scale_sel` is tied 0, and INTT timing equals NTT timing (`done` at 939).

## Test plan
- Reset: hold `rst` 3 cycles, then 5 idle cycles → all outputs 0, no `wr_en_*`.
- NTT start → cycle 1: a=0, b=128, k=1; cycle 128: a=127, b=255, k=1; cycle 805: a=0, b=2, k=64; cycle 932: a=253, b=255, k=127; `done` only at 939.
- INTT start → cycle 1: a=0, b=2, k=127, `bf_mode`=1; cycle 805: a=0, b=128, k=1; every `wr_en` is exactly 6 cycles after its `rd_en` with matching addresses; 896 writes in total.
- `start` pulsed at cycles 50 and 500 of a running NTT → ignored; single `done` at 939; new start at 941 accepted.
- `rst` at cycle 300 of an NTT → next cycle all outputs 0, no further `wr_en` from squashed pairs; restart completes normally in 939 cycles.
- `NTT_INTT_SCALE_EN` INTT → 256 `wr_en_b` pulses with `bf_mode`=2, `scale_sel`=1, addresses 0..255 on cycles 944..1199; `done` at 1200; NTT unaffected (`done` at 939).

Source files
------------

// File: rtl/ntt_scheduler.sv
// Address/twiddle sequencer for one in-place Kyber NTT or INTT over 256 coefficients.
// Optional INTT scale pass (point-wise multiply by f) enabled with `define NTT_INTT_SCALE_EN.
module ntt_scheduler #(
   parameter int RAM_LAT = 1,
   parameter int BF_LAT  = 5,
   parameter int MUL_LAT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       inverse,
   output logic       busy,
   output logic       done,
   output logic [1:0] bf_mode,
   output logic       rd_en,
   output logic [7:0] rd_addr_a,
   output logic [7:0] rd_addr_b,
   output logic [6:0] zeta_idx,
   output logic       scale_sel,
   output logic       wr_en_a,
   output logic       wr_en_b,
   output logic [7:0] wr_addr_a,
   output logic [7:0] wr_addr_b
);

   localparam int PIPE  = RAM_LAT + BF_LAT;
   localparam int SPIPE = RAM_LAT + MUL_LAT;
   localparam int DEPTH = (PIPE > SPIPE) ? PIPE : SPIPE;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN    = 3'd1,
      S_DRAIN  = 3'd2,
      S_SCALE  = 3'd3,
      S_SDRAIN = 3'd4,
      S_FIN    = 3'd5
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [7:0] cnt_q;
   logic [2:0] lyr_q;
   logic       inv_q;

   logic [3:0] sh;
   logic [7:0] p8;
   logic [7:0] len8;
   logic [7:0] grp8;
   logic [7:0] pa;
   logic [7:0] pb;
   logic [6:0] zt;

   logic [DEPTH-1:0] vld_p;
   logic [7:0]       a_p [DEPTH];
   logic [7:0]       b_p [DEPTH];
`ifdef NTT_INTT_SCALE_EN
   logic [DEPTH-1:0] scl_p;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (cnt_q == 8'd127) state_d = S_DRAIN;
         // Every butterfly of this layer must be written back before the next layer reads
         S_DRAIN: begin
            if (cnt_q == 8'(PIPE - 1)) begin
               if (lyr_q != 3'd6) begin
                  state_d = S_RUN;
`ifdef NTT_INTT_SCALE_EN
               end else if (inv_q) begin
                  state_d = S_SCALE;
`endif
               end else begin
                  state_d = S_FIN;
               end
            end
         end
`ifdef NTT_INTT_SCALE_EN
         S_SCALE:  if (cnt_q == 8'd255) state_d = S_SDRAIN;
         S_SDRAIN: if (cnt_q == 8'(SPIPE - 1)) state_d = S_FIN;
`endif
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // cnt_q restarts on every state change, so it is the pair/drain/scale index of the current state
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         lyr_q <= '0;
         inv_q <= 1'b0;
      end else begin
         if (state_q != state_d) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 8'd1;
         end
         if (state_q == S_IDLE && start) begin
            lyr_q <= '0;
            inv_q <= inverse;
         end else if (state_q == S_DRAIN && state_d == S_RUN) begin
            lyr_q <= lyr_q + 3'd1;
         end
      end
   end

   // Butterfly span: NTT halves it every layer (128..2), INTT doubles it (2..128)
   always_comb begin
      sh   = inv_q ? ({1'b0, lyr_q} + 4'd1) : (4'd7 - {1'b0, lyr_q});
      p8   = {1'b0, cnt_q[6:0]};
      len8 = 8'd1 << sh;
      grp8 = p8 >> sh;
      pa   = ((grp8 << 1) << sh) | (p8 & (len8 - 8'd1));
      pb   = pa + len8;
      zt   = inv_q ? 7'((8'd128 >> (sh - 4'd1)) - 8'd1 - grp8)
                   : 7'((8'd128 >> sh) + grp8);
   end

   always_comb begin
      busy      = (state_q != S_IDLE) && (state_q != S_FIN);
      done      = (state_q == S_FIN);
      bf_mode   = (state_q == S_IDLE) ? 2'd0 : {1'b0, inv_q};
      rd_en     = 1'b0;
      rd_addr_a = '0;
      rd_addr_b = '0;
      zeta_idx  = '0;
      scale_sel = 1'b0;
      case (state_q)
         S_RUN: begin
            rd_en     = 1'b1;
            rd_addr_a = pa;
            rd_addr_b = pb;
            zeta_idx  = zt;
         end
`ifdef NTT_INTT_SCALE_EN
         S_SCALE: begin
            rd_en     = 1'b1;
            rd_addr_b = cnt_q;
            scale_sel = 1'b1;
            bf_mode   = 2'd2;
         end
         S_SDRAIN: begin
            bf_mode   = 2'd2;
         end
`endif
         default: begin
         end
      endcase
   end

   // p0: read issued; write-back emerges at the stage matching the datapath latency
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
`ifdef NTT_INTT_SCALE_EN
         scl_p <= '0;
`endif
      end else begin
         vld_p <= {vld_p[DEPTH-2:0], rd_en};
`ifdef NTT_INTT_SCALE_EN
         scl_p <= {scl_p[DEPTH-2:0], scale_sel};
`endif
      end
   end

   always_ff @(posedge clk) begin
      a_p[0] <= rd_addr_a;
      b_p[0] <= rd_addr_b;
      for (int i = 1; i < DEPTH; i++) begin
         a_p[i] <= a_p[i-1];
         b_p[i] <= b_p[i-1];
      end
   end

   always_comb begin
      wr_en_a   = 1'b0;
      wr_en_b   = 1'b0;
      wr_addr_a = '0;
      wr_addr_b = '0;
`ifdef NTT_INTT_SCALE_EN
      if (vld_p[PIPE-1] && !scl_p[PIPE-1]) begin
         wr_en_a   = 1'b1;
         wr_en_b   = 1'b1;
         wr_addr_a = a_p[PIPE-1];
         wr_addr_b = b_p[PIPE-1];
      end else if (vld_p[SPIPE-1] && scl_p[SPIPE-1]) begin
         wr_en_b   = 1'b1;
         wr_addr_b = b_p[SPIPE-1];
      end
`else
      if (vld_p[PIPE-1]) begin
         wr_en_a   = 1'b1;
         wr_en_b   = 1'b1;
         wr_addr_a = a_p[PIPE-1];
         wr_addr_b = b_p[PIPE-1];
      end
`endif
   end

endmodule

// File: tb/tb_ntt_scheduler.sv
// Scoreboard bench for ntt_scheduler: Kyber loop-nest reference model, randomized ops, strays and resets.
module tb_ntt_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       inverse = 1'b0;
   logic       busy, done, rd_en, scale_sel, wr_en_a, wr_en_b;
   logic [1:0] bf_mode;
   logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [6:0] zeta_idx;

   ntt_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .inverse   (inverse),
      .busy      (busy),
      .done      (done),
      .bf_mode   (bf_mode),
      .rd_en     (rd_en),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .zeta_idx  (zeta_idx),
      .scale_sel (scale_sel),
      .wr_en_a   (wr_en_a),
      .wr_en_b   (wr_en_b),
      .wr_addr_a (wr_addr_a),
      .wr_addr_b (wr_addr_b)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef NTT_INTT_SCALE_EN
   localparam bit SCALE_ON = 1'b1;
`else
   localparam bit SCALE_ON = 1'b0;
`endif

   typedef struct {
      int         c;
      logic [7:0] a;
      logic [7:0] b;
      logic [6:0] z;
      logic [1:0] m;
      logic       s;
   } rd_t;

   typedef struct {
      int         c;
      logic       ea;
      logic       eb;
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] m;
   } wr_t;

   rd_t rd_q[$];
   wr_t wr_q[$];
   int  done_q[$];
   int  tests = 0;
   int  fails = 0;
   int  busy_from = 1;
   int  busy_to = 0;
   bit  mon_on = 1'b0;

   task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: Kyber reference loop nests, laid onto the schedule of 134 cycles per layer
   task automatic plan(input bit inv, input int t0, output int dur);
      int n = 0;
      int k = inv ? 127 : 1;
      int len;
      int c;
      logic [1:0] m = inv ? 2'd1 : 2'd0;
      for (int l = 0; l < 7; l++) begin
         len = inv ? (2 << l) : (128 >> l);
         for (int st = 0; st < 256; st += 2 * len) begin
            for (int j = st; j < st + len; j++) begin
               c = t0 + 1 + 134 * (n / 128) + (n % 128);
               rd_q.push_back('{c, 8'(j), 8'(j + len), 7'(k), m, 1'b0});
               wr_q.push_back('{c + 6, 1'b1, 1'b1, 8'(j), 8'(j + len), m});
               n++;
            end
            k = inv ? k - 1 : k + 1;
         end
      end
      dur = 939;
      if (SCALE_ON && inv) begin
         for (int i = 0; i < 256; i++) begin
            rd_q.push_back('{t0 + 939 + i, 8'd0, 8'(i), 7'd0, 2'd2, 1'b1});
            wr_q.push_back('{t0 + 944 + i, 1'b0, 1'b1, 8'd0, 8'(i), 2'd2});
         end
         dur = 1200;
      end
      done_q.push_back(t0 + dur);
      busy_from = t0 + 1;
      busy_to   = t0 + dur - 1;
   endtask

   function automatic logic [63:0] all_outs();
      return {busy, done, bf_mode, rd_en, rd_addr_a, rd_addr_b, zeta_idx, scale_sel,
              wr_en_a, wr_en_b, wr_addr_a, wr_addr_b};
   endfunction

   task automatic run_op(input bit inv, input int s0, input int s1);
      int t0 = cyc;
      int dur;
      plan(inv, t0, dur);
      start = 1'b1;
      inverse = inv;
      tick();
      for (int rel = 1; rel < dur + 2; rel++) begin
         start = (rel == s0) || (rel == s1);
         inverse = 1'($urandom_range(0, 1));
         tick();
      end
      start = 1'b0;
      cmp("rd_q_drained", rd_q.size(), 0);
      cmp("wr_q_drained", wr_q.size(), 0);
      cmp("done_seen", done_q.size(), 0);
   endtask

   task automatic run_rst(input bit inv, input int rc);
      int t0 = cyc;
      int dur;
      plan(inv, t0, dur);
      start = 1'b1;
      inverse = inv;
      tick();
      start = 1'b0;
      for (int rel = 1; rel < rc; rel++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rd_q.delete();
      wr_q.delete();
      done_q.delete();
      busy_to = t0 + rc;
      cmp("post_reset_outs", all_outs(), 0);
      repeat (12) tick();
   endtask

   rd_t r;
   wr_t w;
   always @(negedge clk) begin
      if (mon_on) begin
         cmp("busy", busy, (cyc >= busy_from) && (cyc <= busy_to));
         if (done_q.size() != 0 && done_q[0] == cyc) begin
            cmp("done", done, 1);
            void'(done_q.pop_front());
         end else begin
            cmp("done_quiet", done, 0);
         end
         if (rd_en) begin
            cmp("rd_pending", rd_q.size() != 0, 1);
            if (rd_q.size() != 0) begin
               r = rd_q.pop_front();
               cmp("rd cyc/a/b/zeta/mode/scl",
                   {32'(cyc), rd_addr_a, rd_addr_b, zeta_idx, bf_mode, scale_sel},
                   {32'(r.c), r.a, r.b, r.z, r.m, r.s});
            end
         end else begin
            cmp("rd_idle_zero", {rd_addr_a, rd_addr_b, zeta_idx}, 0);
         end
         if (wr_en_a || wr_en_b) begin
            cmp("wr_pending", wr_q.size() != 0, 1);
            if (wr_q.size() != 0) begin
               w = wr_q.pop_front();
               cmp("wr cyc/en/a/b/mode",
                   {32'(cyc), wr_en_a, wr_en_b, (wr_en_a ? wr_addr_a : 8'd0), wr_addr_b, bf_mode},
                   {32'(w.c), w.ea, w.eb, w.a, w.b, w.m});
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      mon_on = 1'b1;
      repeat (5) begin
         tick();
         cmp("reset_idle_outs", all_outs(), 0);
      end
      run_op(1'b0, 50, 500);
      run_op(1'b1, 0, 0);
      run_rst(1'b0, 300);
      run_op(1'b0, 0, 0);
      repeat (3) begin
         repeat ($urandom_range(0, 4)) tick();
         run_op(1'($urandom_range(0, 1)), $urandom_range(1, 900), $urandom_range(1, 900));
      end
      run_rst(1'($urandom_range(0, 1)), $urandom_range(2, 930));
      run_op(1'b1, $urandom_range(1, 900), 0);
      repeat (4) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
